// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among N_REQ requesters.
// Define RR_STREAM_ARBITER_PKTLOCK_EN to hold the grant until the beat marked last.
module rr_stream_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic                    o_dn_valid,
  input  logic                    i_dn_ready,
  output logic [DATA_W-1:0]       o_dn_data,
  output logic [$clog2(N_REQ)-1:0] o_dn_id,
  output logic                    o_dn_last
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int PW   = ID_W + 1;

  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_REQ-1:0]             eligible;
  logic [ID_W-1:0]              ptr_q, gnt_id, ptr_nxt;
  logic [PW-1:0]                idx;
  logic                         gnt_vld, ld, accept, sel_last, ptr_upd;

  assign req_data = i_req_data;
  assign ld       = !o_dn_valid | i_dn_ready;
  assign accept   = ld & gnt_vld & !i_rst;
  assign sel_last = i_req_last[gnt_id];
  assign o_req_ready = accept ? (N_REQ'(1) << gnt_id) : '0;
  assign ptr_nxt  = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;

  // Rotating search starting at ptr; index folded back into 0..N_REQ-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + PW'(i);
      if (idx >= PW'(N_REQ)) idx = idx - PW'(N_REQ);
      if (!gnt_vld && eligible[idx[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
  end

`ifdef RR_STREAM_ARBITER_PKTLOCK_EN
  typedef enum logic {OPEN, LOCKED} state_t;
  state_t          state_q, state_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;

  // Kept apart from the FSM process: eligible feeds the grant that the FSM consumes.
  always_comb begin
    eligible = i_req_valid;
    if (state_q == LOCKED) eligible = i_req_valid & (N_REQ'(1) << lock_id_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= OPEN;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    ptr_upd   = accept;
    case (state_q)
      OPEN: if (accept && !sel_last) begin
        state_d   = LOCKED;
        lock_id_d = gnt_id;
        ptr_upd   = 1'b0;
      end
      LOCKED: if (accept) begin
        if (sel_last) state_d = OPEN;
        else          ptr_upd = 1'b0;
      end
      default: state_d = OPEN;
    endcase
  end
`else
  assign eligible = i_req_valid;
  assign ptr_upd  = accept;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q      <= '0;
      o_dn_valid <= 1'b0;
      o_dn_data  <= '0;
      o_dn_id    <= '0;
      o_dn_last  <= 1'b0;
    end else begin
      if (ptr_upd) ptr_q <= ptr_nxt;
      if (ld) begin
        o_dn_valid <= accept;
        if (accept) begin
          o_dn_data <= req_data[gnt_id];
          o_dn_id   <= gnt_id;
          o_dn_last <= sel_last;
        end
      end
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed table-driven bench for rr_stream_arbiter (N_REQ=4, DATA_W=8).
module tb_rr_stream_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, dnr;
  logic [N-1:0]   valid, last, ready;
  logic [N*W-1:0] req_data;
  logic           dv, dlast;
  logic [W-1:0]   ddata;
  logic [1:0]     did;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  rr_stream_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(valid), .o_req_ready(ready),
    .i_req_data(req_data), .i_req_last(last),
    .o_dn_valid(dv), .i_dn_ready(dnr),
    .o_dn_data(ddata), .o_dn_id(did), .o_dn_last(dlast)
  );

  typedef struct {
    logic [3:0] v;
    logic       d;
    logic [3:0] rdy;
    logic       dv;
    logic [1:0] id;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; everything is sampled 1ns later.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l, input logic d);
    @(negedge clk);
    rst = r; valid = v; last = l; dnr = d;
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] rdy, input logic edv,
                           input logic [1:0] eid, input logic elast);
    chk({tag, "_rdy"}, 32'(ready), 32'(rdy));
    chk({tag, "_dv"}, 32'(dv), 32'(edv));
    if (edv) begin
      chk({tag, "_id"}, 32'(did), 32'(eid));
      chk({tag, "_data"}, 32'(ddata), 32'(8'hA0 + 8'(eid)));
      chk({tag, "_last"}, 32'(dlast), 32'(elast));
    end
  endtask

  initial begin
    // all requesters, drain each cycle: 0,1,2,3,0
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd0};
    // requester 2 alone, five cycles of backpressure
    tbl[6]  = '{4'h4, 1'b0, 4'b0100, 1'b0, 2'd0};
    tbl[7]  = '{4'h4, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[8]  = '{4'h4, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[9]  = '{4'h4, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[10] = '{4'h4, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[11] = '{4'h4, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[12] = '{4'h4, 1'b1, 4'b0100, 1'b1, 2'd2};
    // ptr=3 with 1001, then 0001 wraps back to 0
    tbl[13] = '{4'h9, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[14] = '{4'h9, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[15] = '{4'h1, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[16] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[17] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};

    rst = 1'b1; valid = '0; last = '0; dnr = 1'b0;
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    chk("rst_ready_forced", 32'(ready), 32'd0);
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    chk("rst_dv", 32'(dv), 32'd0);
    chk("rst_data", 32'(ddata), 32'd0);
    chk("rst_id", 32'(did), 32'd0);
    chk("rst_last", 32'(dlast), 32'd0);

    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'h0, 4'h0, 1'b1);
      expect_st($sformatf("idle%0d", k), 4'b0000, 1'b0, 2'd0, 1'b0);
    end

    for (int i = 0; i < 18; i++) begin
      drive(1'b0, tbl[i].v, 4'hF, tbl[i].d);
      expect_st($sformatf("tbl%0d", i), tbl[i].rdy, tbl[i].dv, tbl[i].id, 1'b1);
    end

`ifdef RR_STREAM_ARBITER_PKTLOCK_EN
    // requester 1 sends three beats with a two-cycle gap; requester 0 waits
    drive(1'b0, 4'b0011, 4'b0000, 1'b1); expect_st("pk0", 4'b0010, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1); expect_st("pk1", 4'b0010, 1'b1, 2'd1, 1'b0);
    drive(1'b0, 4'b0001, 4'b0000, 1'b1); expect_st("pk2_gap", 4'b0000, 1'b1, 2'd1, 1'b0);
    drive(1'b0, 4'b0001, 4'b0000, 1'b1); expect_st("pk3_gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 4'b0011, 4'b0010, 1'b1); expect_st("pk4", 4'b0010, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 4'b0001, 4'b0001, 1'b1); expect_st("pk5", 4'b0001, 1'b1, 2'd1, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1); expect_st("pk6", 4'b0000, 1'b1, 2'd0, 1'b1);
`else
    // last=0 only propagates; arbitration still moves on the next beat
    drive(1'b0, 4'b0011, 4'b0000, 1'b1); expect_st("nl0", 4'b0010, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1); expect_st("nl1", 4'b0001, 1'b1, 2'd1, 1'b0);
`endif

    // reset with a full output register (and a held lock when enabled)
    drive(1'b0, 4'b0100, 4'b0000, 1'b1);
    chk("rs0_rdy", 32'(ready), 32'b0100);
    drive(1'b0, 4'b1111, 4'b0000, 1'b0);
    expect_st("rs1", 4'b0000, 1'b1, 2'd2, 1'b0);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0);
    chk("rs2_rdy", 32'(ready), 32'd0);
    drive(1'b0, 4'b1010, 4'b0000, 1'b1);
    expect_st("rs3", 4'b0010, 1'b0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
